// File: rtl/saida_serial_seq_pkg.sv
// Shared definitions for the serial digit sequencer: FSM state codes and ASCII constants.
// Also holds the BCD-to-ASCII helper used by the character mux.
package saida_serial_seq_pkg;

    localparam logic [2:0] INICIAL = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] AVALIA  = 3'd2;
    localparam logic [2:0] ENVIA   = 3'd3;
    localparam logic [2:0] ESPERA  = 3'd4;
    localparam logic [2:0] PROXIMO = 3'd5;
    localparam logic [2:0] FIM     = 3'd6;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ERRO = 8'h3F;

    // Nibbles above 9 are not valid BCD and are shown as '?'.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_ERRO : (ASCII_ZERO + {4'h0, d});
    endfunction

endpackage

// File: rtl/saida_serial_seq_uc.sv
// Control FSM of the serial digit sequencer; Moore outputs decoded from the state register.
// Latency: outputs follow the state directly; waits in ESPERA until the transmitter reports done.
module saida_serial_seq_uc
    import saida_serial_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inicio,
    input  logic       tx_pronto,
    input  logic       pula,
    input  logic       ultimo,
    output logic [2:0] estado,
    output logic       tx_partida,
    output logic       pronto,
    output logic       ocupado
);

    logic [2:0] proximo_estado;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= INICIAL;
        else          estado <= proximo_estado;
    end

    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL: proximo_estado = inicio ? CARREGA : INICIAL;
            CARREGA: proximo_estado = AVALIA;
            AVALIA:  proximo_estado = pula ? PROXIMO : ENVIA;
            ENVIA:   proximo_estado = ESPERA;
            ESPERA:  proximo_estado = tx_pronto ? PROXIMO : ESPERA;
            PROXIMO: proximo_estado = ultimo ? FIM : AVALIA;
            FIM:     proximo_estado = INICIAL;
            default: proximo_estado = INICIAL;
        endcase
    end

    assign tx_partida = (estado == ENVIA);
    assign pronto     = (estado == FIM);
    assign ocupado    = (estado != INICIAL);

endmodule

// File: rtl/saida_serial_seq.sv
// Sends N_DIGITOS BCD digits (MSB first, optional leading-zero suppression) plus terminator to a serial TX.
// Latency: 3 cycles inicio->first tx_partida; one character in flight, held until tx_pronto.
module saida_serial_seq
    import saida_serial_seq_pkg::*;
#(
    parameter int          N_DIGITOS      = 3,
    parameter int          USA_TERMINADOR = 1,
    parameter logic [7:0]  TERMINADOR     = 8'h23
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   inicio,
    input  logic                   suprime_zeros,
    input  logic [4*N_DIGITOS-1:0] digitos,
    input  logic                   tx_pronto,
    output logic                   tx_partida,
    output logic [7:0]             tx_dado,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [2:0]             db_estado,
    output logic [3:0]             db_indice
);

    localparam logic [3:0] ULTIMO_DIGITO = 4'(N_DIGITOS - 1);
    localparam logic [3:0] ULTIMO_CHAR   = 4'(N_DIGITOS + USA_TERMINADOR - 1);
    localparam logic [3:0] IDX_TERM      = 4'(N_DIGITOS);

    logic [2:0]             estado;
    logic [4*N_DIGITOS-1:0] digitos_reg;
    logic                   suprime;
    logic [3:0]             indice;
    logic [3:0]             digito_atual;
    logic [7:0]             caractere;
    logic                   pula;
    logic                   ultimo;

    saida_serial_seq_uc u_uc (
        .clock      (clock),
        .reset_n    (reset_n),
        .inicio     (inicio),
        .tx_pronto  (tx_pronto),
        .pula       (pula),
        .ultimo     (ultimo),
        .estado     (estado),
        .tx_partida (tx_partida),
        .pronto     (pronto),
        .ocupado    (ocupado)
    );

    // Index 0 is the most significant nibble; the terminator index reads as digit 0.
    always_comb begin
        digito_atual = 4'h0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (indice == 4'(i)) digito_atual = digitos_reg[4*(N_DIGITOS-1-i) +: 4];
        end
    end

    always_comb begin
        caractere = bcd_ascii(digito_atual);
        if (USA_TERMINADOR != 0 && indice == IDX_TERM) caractere = TERMINADOR;
    end

    // The last digit is never skipped, so an all-zero value still prints "0".
    assign pula   = suprime && (indice < ULTIMO_DIGITO) && (digito_atual == 4'h0);
    assign ultimo = (indice == ULTIMO_CHAR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digitos_reg <= '0;
            suprime     <= 1'b0;
            indice      <= 4'h0;
            tx_dado     <= 8'h00;
        end else begin
            case (estado)
                CARREGA: begin
                    digitos_reg <= digitos;
                    suprime     <= suprime_zeros;
                    indice      <= 4'h0;
                end
                AVALIA: begin
                    if (!pula) begin
                        tx_dado <= caractere;
                        if (digito_atual != 4'h0) suprime <= 1'b0;
                    end
                end
                PROXIMO: begin
                    if (!ultimo) indice <= indice + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign db_estado = estado;
    assign db_indice = indice;

endmodule

// File: tb/tb_saida_serial_seq.sv
// Directed bench for saida_serial_seq: default build (3 digits + '#') and a 4-digit build without terminator.
module tb_saida_serial_seq;

    logic        clock;
    logic        reset_n;
    logic        suprime_zeros;
    logic        tx_pronto;
    logic        inicio_a, inicio_b;
    logic [11:0] digitos_a;
    logic [15:0] digitos_b;
    logic        tx_partida_a, tx_partida_b;
    logic [7:0]  tx_dado_a, tx_dado_b;
    logic        ocupado_a, ocupado_b;
    logic        pronto_a, pronto_b;
    logic [2:0]  db_estado_a, db_estado_b;
    logic [3:0]  db_indice_a, db_indice_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] cap[$];
    int n_part, n_pronto, first_c, idx_fim;

    saida_serial_seq #(.N_DIGITOS(3), .USA_TERMINADOR(1), .TERMINADOR(8'h23)) dut_a (
        .clock(clock), .reset_n(reset_n), .inicio(inicio_a), .suprime_zeros(suprime_zeros),
        .digitos(digitos_a), .tx_pronto(tx_pronto), .tx_partida(tx_partida_a), .tx_dado(tx_dado_a),
        .ocupado(ocupado_a), .pronto(pronto_a), .db_estado(db_estado_a), .db_indice(db_indice_a)
    );

    saida_serial_seq #(.N_DIGITOS(4), .USA_TERMINADOR(0), .TERMINADOR(8'h23)) dut_b (
        .clock(clock), .reset_n(reset_n), .inicio(inicio_b), .suprime_zeros(suprime_zeros),
        .digitos(digitos_b), .tx_pronto(tx_pronto), .tx_partida(tx_partida_b), .tx_dado(tx_dado_b),
        .ocupado(ocupado_b), .pronto(pronto_b), .db_estado(db_estado_b), .db_indice(db_indice_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one message on DUT a (sel=0) or b (sel=1) with a transmitter that answers 5 cycles after
    // each start pulse. rst_at != 0 pulls reset during ESPERA of that character instead of finishing.
    task automatic run_msg(input bit sel, input logic [15:0] dig, input logic sup, input int rst_at);
        int  espera;
        bit  done;
        logic part, pr;
        logic [7:0] dd;
        logic [2:0] est;
        logic [3:0] idx;
        cap.delete();
        n_part = 0; n_pronto = 0; first_c = -1; idx_fim = 0;
        espera = 0; done = 0;
        suprime_zeros = sup;
        if (sel) begin digitos_b = dig; inicio_b = 1'b1; end
        else     begin digitos_a = dig[11:0]; inicio_a = 1'b1; end
        @(negedge clock);
        inicio_a = 1'b0; inicio_b = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            if (c == 0) begin digitos_a = '1; digitos_b = '1; suprime_zeros = ~sup; end
            inicio_a = 1'b0; inicio_b = 1'b0; tx_pronto = 1'b0;
            part = sel ? tx_partida_b : tx_partida_a;
            pr   = sel ? pronto_b : pronto_a;
            dd   = sel ? tx_dado_b : tx_dado_a;
            est  = sel ? db_estado_b : db_estado_a;
            idx  = sel ? db_indice_b : db_indice_a;
            if (part) begin
                cap.push_back(dd);
                n_part++;
                espera = 5;
                if (first_c < 0) first_c = c;
            end else if (espera > 0) begin
                espera--;
                if (espera == 0) tx_pronto = 1'b1;
                if (espera == 2) begin
                    if (sel) inicio_b = 1'b1; else inicio_a = 1'b1;
                end
            end
            if (rst_at != 0 && n_part == rst_at && espera == 3) begin
                check("pre_rst_estado", 32'(est), 32'd4);
                reset_n = 1'b0;
                done = 1;
            end
            if (pr) begin
                n_pronto++;
                idx_fim = int'(idx);
                done = 1;
            end
        end
        check("timeout", 32'(done), 32'd1);
        tx_pronto = 1'b0;
        if (rst_at == 0) begin
            @(negedge clock);
            check("pronto_one_cycle", 32'(sel ? pronto_b : pronto_a), 32'd0);
            check("ocupado_after", 32'(sel ? ocupado_b : ocupado_a), 32'd0);
        end
    endtask

    task automatic expect_msg(input string tag, input int n, input logic [31:0] exp);
        check({tag, "_partidas"}, 32'(n_part), 32'(n));
        check({tag, "_pronto"}, 32'(n_pronto), 32'd1);
        for (int i = 0; i < n && i < cap.size(); i++)
            check({tag, "_char"}, 32'(cap[i]), 32'(exp[8*(n-1-i) +: 8]));
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_partida"}, 32'(tx_partida_a), 32'd0);
        check({tag, "_dado"},    32'(tx_dado_a),    32'd0);
        check({tag, "_pronto"},  32'(pronto_a),     32'd0);
        check({tag, "_ocupado"}, 32'(ocupado_a),    32'd0);
        check({tag, "_estado"},  32'(db_estado_a),  32'd0);
        check({tag, "_indice"},  32'(db_indice_a),  32'd0);
        check({tag, "_estado_b"}, 32'(db_estado_b), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; suprime_zeros = 1'b0; tx_pronto = 1'b0;
        inicio_a = 1'b0; inicio_b = 1'b0; digitos_a = '0; digitos_b = '0;
        repeat (2) @(negedge clock);
        check_idle_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        run_msg(1'b0, 16'h042, 1'b0, 0);
        expect_msg("m042", 4, 32'h30343223);
        check("lat_first_partida", 32'(first_c), 32'd1);
        check("idx_at_fim", 32'(idx_fim), 32'd3);

        run_msg(1'b0, 16'h042, 1'b1, 0);
        expect_msg("m042_sup", 3, 32'h00343223);
        check("lat_after_skip", 32'(first_c), 32'd3);

        run_msg(1'b0, 16'h000, 1'b1, 0);
        expect_msg("m000_sup", 2, 32'h00003023);

        run_msg(1'b0, 16'h1A5, 1'b0, 0);
        expect_msg("m1A5", 4, 32'h313F3523);

        run_msg(1'b1, 16'h9051, 1'b0, 0);
        expect_msg("b9051", 4, 32'h39303531);
        check("b_idx_at_fim", 32'(idx_fim), 32'd3);

        run_msg(1'b1, 16'h0070, 1'b1, 0);
        expect_msg("b0070_sup", 2, 32'h00003730);

        run_msg(1'b0, 16'h042, 1'b0, 2);
        #1;
        check_idle_zero("mid_rst");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_msg(1'b0, 16'h042, 1'b0, 0);
        expect_msg("after_rst", 4, 32'h30343223);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
